irq_priority_encoder: RTL and testbench
=======================================

// Module: irq_priority_encoder
// PURPOSE
//   Inverse of the machine's 3-to-8 select decoders: an 8-to-3 priority encoder for interrupt requests.
//   - Latches falling edges on eight active-low request lines (74F148 polarity).
//   - Presents the winning 3-bit code with a valid flag and holds it stable until the CPU acknowledges.
//   - Sits between the board request lines and the pine16 interrupt unit.
// PARAMETERS
//   PRIO_HIGH  1  1: line 7 has highest priority (74F148 order); 0: line 0 has highest priority
// PORTS
//   clk     in   1  system clock, rising edge
//   rst     in   1  synchronous reset, active-high
//   req_n   in   8  request lines, active-low; falling edge = new request
//   ei_n    in   1  enable input, active-low; high blocks capture of new edges
//   ack     in   1  acknowledge of the presented code; sampled only in PRESENT
//   code    out  3  index of the presented request; same bit order as decoder {A,B,C}, A = MSB
//   valid   out  1  code is valid and stable
//   gs_n    out  1  active-low "any request pending" (pending != 0)
//   eo_n    out  1  active-low "enabled and nothing pending" (= ei_n | |pending)
// BEHAVIOUR
//   - Reset (rst=1 at clk edge):
//     - pending=8'h00, req_prev_n=8'hFF, state=IDLE, code=3'd0, valid=0.
//     - Hence gs_n=1, and eo_n=ei_n.
//     - A line held low through reset release is captured as an edge one clock later.
//   - Edge capture, every edge: edge = req_prev_n & ~req_s.
//     - req_prev_n <= req_s, including while ei_n=1.
//     - req_s is req_n, or the synchronized copy of it (see CONFIGURATION).
//   - pending update, every edge: pending <= (pending & ~clr) | (ei_n ? 0 : edge).
//     - clr is the one-hot of code, asserted only on an ack accepted in PRESENT.
//     - Set wins over clear: a new edge on the line being acked at that same edge stays pending.
//     - ei_n=1 blocks new captures only; existing pending bits are retained.
//   - State machine:
//     - IDLE:
//       - valid=0.
//       - If pending!=0 at the edge: code <= highest-priority set bit of pending, then go to PRESENT.
//     - PRESENT:
//       - valid=1; code frozen, even if higher-priority bits arrive.
//       - ack=1 at the edge: clear pending[code], go to IDLE.
//       - ack=0: stay in PRESENT.
//     - ack in IDLE is ignored.
//     - At least one IDLE cycle separates consecutive presentations, so valid drops for >= 1 cycle between codes.
//   - Latency without sync: req_n low before edge N -> pending set after N -> valid=1 and code driven after N+1.
//   - Throughput: 2 clocks per request at best (PRESENT+ack, then IDLE).
//   - Repeat edges: a second edge on an already-pending line merges (no counting, no loss flag).
//   - Level-only: a line held low produces exactly one request.
//   - Outputs valid and code are registered; gs_n and eo_n are combinational from pending and ei_n only.
//   - Reset mid-PRESENT: the request is dropped and valid=0 next cycle; no ack is required.
// CONFIGURATION
//   IRQ_SYNC2_EN
//   - Defined: req_n passes through a 2-flop synchronizer (reset value 8'hFF) before edge detect; req_s = synchronized copy.
//     - Latency becomes 4 clocks (req_n low -> valid).
//     - Pulses on req_n shorter than 1 clk may be missed.
//   - Undefined: req_s = req_n directly; latency 2 clocks.
//     - Caller must guarantee req_n is synchronous to clk.
// TESTING (PRIO_HIGH=1, IRQ_SYNC2_EN undefined unless noted)
//   - Reset:
//     - Stimulus: rst=1 for 2 clk with req_n=8'hFF, ei_n=0.
//     - Required: valid=0, code=0, gs_n=1, eo_n=0.
//   - Single request:
//     - Stimulus: req_n=8'hDF (line 5) at edge N.
//     - Required: gs_n=0 after N; valid=1, code=3'd5 after N+1.
//     - Stimulus: ack=1 for 1 clk.
//     - Required: valid=0, gs_n=1 next cycle.
//   - Priority and freeze:
//     - Stimulus: lines 2 and 6 fall on the same edge.
//     - Required: code=6 first.
//     - Stimulus: line 7 falls while 6 is presented.
//     - Required: code stays 6 until ack; then 1 IDLE cycle, then code=7, then code=2.
//   - PRIO_HIGH=0:
//     - Stimulus: lines 2 and 6 fall together.
//     - Required: code=2 first, then 6.
//   - Enable and set-wins:
//     - Stimulus: ei_n=1 while line 3 falls.
//     - Required: no capture, gs_n=1, eo_n=1.
//     - Stimulus: line 4 re-falls on the same edge as ack of code=4.
//     - Required: code 4 presented again.
//   - Sync option and reset mid-op:
//     - Stimulus: IRQ_SYNC2_EN defined, req_n=8'hFE.
//     - Required: valid=1, code=0 exactly 4 clk later.
//     - Stimulus: rst=1 while PRESENT.
//     - Required: valid=0 next clk, pending cleared.

Source files
------------

// File: rtl/irq_priority_encoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// irq_priority_encoder: 8-to-3 edge-latched interrupt priority encoder (74F148 polarity).
// Optional macro IRQ_SYNC2_EN adds a 2-flop input synchronizer.  Rev 1.0
// ----------------------------------------------------------------------------
module irq_priority_encoder #(
  parameter int PRIO_HIGH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_n,
  input  logic       ei_n,
  input  logic       ack,
  output logic [2:0] code,
  output logic       valid,
  output logic       gs_n,
  output logic       eo_n
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  logic [7:0] req_s;
  logic [7:0] req_prev_n_q, req_prev_n_d;
  logic [7:0] pending_q, pending_d;
  logic [0:0] state_q, state_d;
  logic [2:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic [7:0] edge_det;
  logic [7:0] clr;
  logic [2:0] win;

`ifdef IRQ_SYNC2_EN
  logic [7:0] sync1_q, sync1_d;
  logic [7:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = req_n;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 8'hFF;
      sync2_q <= 8'hFF;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign req_s = sync2_q;
`else
  assign req_s = req_n;
`endif

  // Winner scan: the last set bit visited in loop order wins.
  always_comb begin
    win = 3'd0;
    if (PRIO_HIGH != 0) begin
      for (int i = 0; i < 8; i++) begin
        if (pending_q[i]) win = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (pending_q[i]) win = 3'(i);
      end
    end
  end

  always_comb begin
    edge_det     = req_prev_n_q & ~req_s;
    req_prev_n_d = req_s;
    clr          = ((state_q == ST_PRESENT) && ack) ? (8'd1 << code_q) : 8'd0;
    // Applying the set after the clear lets a fresh edge survive its own ack.
    pending_d    = (pending_q & ~clr) | (ei_n ? 8'h00 : edge_det);

    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE: begin
        if (pending_q != 8'h00) begin
          code_d  = win;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_PRESENT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_prev_n_q <= 8'hFF;
      pending_q    <= 8'h00;
      state_q      <= ST_IDLE;
      code_q       <= 3'd0;
      valid_q      <= 1'b0;
    end else begin
      req_prev_n_q <= req_prev_n_d;
      pending_q    <= pending_d;
      state_q      <= state_d;
      code_q       <= code_d;
      valid_q      <= valid_d;
    end
  end

  assign code  = code_q;
  assign valid = valid_q;
  assign gs_n  = ~(|pending_q);
  assign eo_n  = ei_n | (|pending_q);

endmodule
`default_nettype wire

// File: tb/tb_irq_priority_encoder.sv
`default_nettype none
// tb_irq_priority_encoder: directed + random checks of both priority orders
// against a behavioural model of the request/present/ack protocol.
module tb_irq_priority_encoder;

`ifdef IRQ_SYNC2_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  localparam int PEND_LAT = LAT - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_n = 8'hFF;
  logic       ei_n = 1'b0;
  logic       ack = 1'b0;
  logic [2:0] code_hi, code_lo;
  logic       valid_hi, valid_lo, gs_n_hi, gs_n_lo, eo_n_hi, eo_n_lo;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  irq_priority_encoder #(.PRIO_HIGH(1)) u_dut_hi (
    .clk(clk), .rst(rst), .req_n(req_n), .ei_n(ei_n), .ack(ack),
    .code(code_hi), .valid(valid_hi), .gs_n(gs_n_hi), .eo_n(eo_n_hi)
  );

  irq_priority_encoder #(.PRIO_HIGH(0)) u_dut_lo (
    .clk(clk), .rst(rst), .req_n(req_n), .ei_n(ei_n), .ack(ack),
    .code(code_lo), .valid(valid_lo), .gs_n(gs_n_lo), .eo_n(eo_n_lo)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Highest index via log2 of (p+1); lowest via isolating the least significant set bit.
  function automatic logic [2:0] pick(input logic [7:0] p, input bit hi_first);
    int v;
    int l;
    v = int'(p);
    if (hi_first) return 3'($clog2(v + 1) - 1);
    l = v & (-v);
    return 3'($clog2(l));
  endfunction

  // ---------------- behavioural model: index 0 = PRIO_HIGH=1, 1 = PRIO_HIGH=0
  logic [7:0] m_pend [2];
  bit         m_busy [2];
  logic [2:0] m_code [2];
  logic [7:0] m_prev;
  bit         cmp_en = 1'b0;
`ifdef IRQ_SYNC2_EN
  logic [7:0] m_s1, m_s2;
  function automatic logic [7:0] req_seen();
    return m_s2;
  endfunction
`else
  function automatic logic [7:0] req_seen();
    return req_n;
  endfunction
`endif

  function automatic logic [7:0] clr_mask(input int p);
    if (m_busy[p] && ack) return 8'(1 << m_code[p]);
    return 8'h00;
  endfunction

  always @(posedge clk) begin
`ifdef IRQ_SYNC2_EN
    m_s1 <= rst ? 8'hFF : req_n;
    m_s2 <= rst ? 8'hFF : m_s1;
`endif
    if (rst) begin
      cmp_en <= 1'b1;
      m_prev <= 8'hFF;
      for (int p = 0; p < 2; p++) begin
        m_pend[p] <= 8'h00;
        m_busy[p] <= 1'b0;
        m_code[p] <= 3'd0;
      end
    end else begin
      m_prev <= req_seen();
      for (int p = 0; p < 2; p++) begin
        m_pend[p] <= (m_pend[p] & ~clr_mask(p)) | (ei_n ? 8'h00 : (m_prev & ~req_seen()));
        if (!m_busy[p]) begin
          if (m_pend[p] != 8'h00) begin
            m_busy[p] <= 1'b1;
            m_code[p] <= pick(m_pend[p], p == 0);
          end
        end else if (ack) begin
          m_busy[p] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("hi_valid", {7'd0, valid_hi}, {7'd0, m_busy[0]});
      chk("hi_code",  {5'd0, code_hi},  {5'd0, m_code[0]});
      chk("hi_gs_n",  {7'd0, gs_n_hi},  {7'd0, ~(|m_pend[0])});
      chk("hi_eo_n",  {7'd0, eo_n_hi},  {7'd0, ei_n | (|m_pend[0])});
      chk("lo_valid", {7'd0, valid_lo}, {7'd0, m_busy[1]});
      chk("lo_code",  {5'd0, code_lo},  {5'd0, m_code[1]});
      chk("lo_gs_n",  {7'd0, gs_n_lo},  {7'd0, ~(|m_pend[1])});
      chk("lo_eo_n",  {7'd0, eo_n_lo},  {7'd0, ei_n | (|m_pend[1])});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_once();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  // ---------------- stimulus with hand-computed expectations
  initial begin
    tick();
    tick();
    chk("rst_valid", {7'd0, valid_hi}, 8'd0);
    chk("rst_code",  {5'd0, code_hi},  8'd0);
    chk("rst_gs_n",  {7'd0, gs_n_hi},  8'd1);
    chk("rst_eo_n",  {7'd0, eo_n_hi},  8'd0);
    rst = 1'b0;

    // Single request on line 5
    req_n = 8'hDF;
    repeat (PEND_LAT) tick();
    chk("single_gs_n", {7'd0, gs_n_hi}, 8'd0);
    chk("single_early_valid", {7'd0, valid_hi}, 8'd0);
    tick();
    chk("single_valid", {7'd0, valid_hi}, 8'd1);
    chk("single_code",  {5'd0, code_hi},  8'd5);
    ack_once();
    chk("single_ack_valid", {7'd0, valid_hi}, 8'd0);
    chk("single_ack_gs_n",  {7'd0, gs_n_hi},  8'd1);
    req_n = 8'hFF;
    repeat (4) tick();

    // Lines 2 and 6 together, then 7 while 6 is presented
    req_n = 8'hBB;
    repeat (LAT) tick();
    chk("prio_hi_first", {5'd0, code_hi}, 8'd6);
    chk("prio_lo_first", {5'd0, code_lo}, 8'd2);
    req_n = 8'h3B;
    repeat (LAT + 1) tick();
    chk("freeze_code",  {5'd0, code_hi},  8'd6);
    chk("freeze_valid", {7'd0, valid_hi}, 8'd1);
    ack_once();
    chk("gap_valid", {7'd0, valid_hi}, 8'd0);
    tick();
    chk("prio_hi_second", {5'd0, code_hi}, 8'd7);
    chk("prio_lo_second", {5'd0, code_lo}, 8'd6);
    ack_once();
    tick();
    chk("prio_hi_third", {5'd0, code_hi}, 8'd2);
    chk("prio_lo_third", {5'd0, code_lo}, 8'd7);
    ack_once();
    req_n = 8'hFF;
    repeat (4) tick();
    chk("prio_drained_gs_n", {7'd0, gs_n_hi}, 8'd1);

    // Enable blocks capture of line 3
    ei_n  = 1'b1;
    req_n = 8'hF7;
    repeat (LAT + 1) tick();
    chk("ei_gs_n",  {7'd0, gs_n_hi},  8'd1);
    chk("ei_eo_n",  {7'd0, eo_n_hi},  8'd1);
    chk("ei_valid", {7'd0, valid_hi}, 8'd0);
    ei_n = 1'b0;
    tick();
    chk("ei_reenable_eo_n", {7'd0, eo_n_hi}, 8'd0);
    tick();
    chk("ei_level_only", {7'd0, valid_hi}, 8'd0);
    req_n = 8'hFF;
    repeat (4) tick();

    // Line 4 re-falls on the edge that acks code 4
    req_n = 8'hEF;
    repeat (LAT) tick();
    chk("setwin_first_code", {5'd0, code_hi}, 8'd4);
    req_n = 8'hFF;
    repeat (PEND_LAT) tick();
    req_n = 8'hEF;
    repeat (PEND_LAT - 1) tick();
    ack_once();
    chk("setwin_idle_valid", {7'd0, valid_hi}, 8'd0);
    chk("setwin_kept_gs_n",  {7'd0, gs_n_hi},  8'd0);
    tick();
    chk("setwin_again_valid", {7'd0, valid_hi}, 8'd1);
    chk("setwin_again_code",  {5'd0, code_hi},  8'd4);
    ack_once();
    req_n = 8'hFF;
    repeat (4) tick();

    // Line 0, then reset while presenting
    req_n = 8'hFE;
    repeat (LAT) tick();
    chk("lat_valid", {7'd0, valid_hi}, 8'd1);
    chk("lat_code",  {5'd0, code_hi},  8'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", {7'd0, valid_hi}, 8'd0);
    chk("midrst_gs_n",  {7'd0, gs_n_hi},  8'd1);
    repeat (LAT) tick();
    chk("held_low_recapture", {7'd0, valid_hi}, 8'd1);
    ack_once();
    req_n = 8'hFF;
    repeat (4) tick();

    // Random traffic; the compare process checks every cycle
    for (int c = 0; c < 3000; c++) begin
      req_n = req_n ^ 8'($urandom & $urandom & $urandom);
      ei_n  = ($urandom_range(0, 9) == 0);
      ack   = ($urandom_range(0, 2) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    ack = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
